// File: rtl/register_inc_wrap.sv
// Index counter with programmable limit, up/down stepping, wrap or saturate
// behaviour, terminal-count flags and a registered wrap pulse for chaining.
module register_inc_wrap #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STEP      = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic             inc,
    input  logic             dec,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             at_limit,
    output logic             zero,
    output logic             wrap_pulse
);

    localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);

    logic [WIDTH:0]   up_sum;
    logic             up_fits;
    logic             down_fits;
    logic [WIDTH-1:0] next_data;
    logic             next_pulse;

    // One extra bit keeps overflow past the top of the range visible, so it
    // always counts as exceeding the limit instead of wrapping silently.
    assign up_sum    = {1'b0, data_out} + STEP_EXT;
    assign up_fits   = (up_sum <= {1'b0, limit});
    assign down_fits = ({1'b0, data_out} >= STEP_EXT);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_data  = data_out;
        next_pulse = 1'b0;
        if (clr) begin
            next_data = '0;
        end else if (we) begin
            next_data = data_in;
        end else if (inc && !dec) begin
            if (up_fits) begin
                next_data = up_sum[WIDTH-1:0];
            end else if (sat_mode) begin
                next_data = limit;
            end else begin
                next_data  = '0;
                next_pulse = 1'b1;
            end
        end else if (dec && !inc) begin
            if (down_fits) begin
                next_data = data_out - STEP_EXT[WIDTH-1:0];
            end else if (sat_mode) begin
                next_data = '0;
            end else begin
                next_data  = limit;
                next_pulse = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= RESET_CNT;
            wrap_pulse <= 1'b0;
        end else begin
            data_out   <= next_data;
            wrap_pulse <= next_pulse;
        end
    end

    assign at_limit = (data_out == limit);
    assign zero     = (data_out == '0);

endmodule

// File: tb/tb_register_inc_wrap.sv
// Directed bench for register_inc_wrap: three instances (STEP 1/3/10) share
// one control bus; each scenario loads known state before checking its instance.
module tb_register_inc_wrap;

    logic       clk;
    logic       rst_n;
    logic       clr, we, inc, dec, sat_mode;
    logic [7:0] limit, data_in;

    logic [7:0] d1, d3, d10;
    logic       al1, al3, al10;
    logic       z1, z3, z10;
    logic       wp1, wp3, wp10;

    int n_cmp = 0;
    int n_err = 0;

    register_inc_wrap #(.WIDTH(8), .STEP(1), .RESET_VAL(5)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .inc(inc), .dec(dec),
        .sat_mode(sat_mode), .limit(limit), .data_in(data_in),
        .data_out(d1), .at_limit(al1), .zero(z1), .wrap_pulse(wp1)
    );

    register_inc_wrap #(.WIDTH(8), .STEP(3), .RESET_VAL(0)) u_dut_s3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .inc(inc), .dec(dec),
        .sat_mode(sat_mode), .limit(limit), .data_in(data_in),
        .data_out(d3), .at_limit(al3), .zero(z3), .wrap_pulse(wp3)
    );

    register_inc_wrap #(.WIDTH(8), .STEP(10), .RESET_VAL(0)) u_dut_s10 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .inc(inc), .dec(dec),
        .sat_mode(sat_mode), .limit(limit), .data_in(data_in),
        .data_out(d10), .at_limit(al10), .zero(z10), .wrap_pulse(wp10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; we = 0; inc = 0; dec = 0;
    endtask

    task automatic load(input logic [7:0] v);
        idle();
        we = 1; data_in = v;
        tick();
        we = 0;
    endtask

    int exp_wrap_up[5]   = '{1, 2, 3, 0, 1};
    int exp_wrap_upp[5]  = '{0, 0, 0, 1, 0};
    int exp_sat_up[5]    = '{3, 6, 9, 10, 10};
    int exp_sat_dn[5]    = '{7, 4, 1, 0, 0};
    int exp_dwrap[3]     = '{0, 7, 6};
    int exp_dwrap_p[3]   = '{0, 1, 0};

    initial begin
        rst_n = 0; idle(); sat_mode = 0; limit = 8'd0; data_in = 8'd0;

        // Reset state and hold after release
        #12;
        check("rst_data", d1, 5);
        check("rst_pulse", wp1, 0);
        check("rst_zero", z1, 0);
        check("rst_zero_s3", z3, 1);
        rst_n = 1;
        limit = 8'd20;
        tick();
        check("hold_after_rst", d1, 5);
        tick();
        check("hold_after_rst2", d1, 5);

        // Wrap up, STEP=1, limit=3
        limit = 8'd3; sat_mode = 0;
        clr = 1; tick(); clr = 0;
        check("clr_data", d1, 0);
        check("clr_zero", z1, 1);
        inc = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("wrap_up_data[%0d]", i), d1, exp_wrap_up[i]);
            check($sformatf("wrap_up_pulse[%0d]", i), wp1, exp_wrap_upp[i]);
            check($sformatf("wrap_up_atlim[%0d]", i), al1, (exp_wrap_up[i] == 3) ? 1 : 0);
        end
        idle();

        // Asynchronous reset mid-cycle while a wrap pulse is high
        load(8'd3);
        inc = 1; tick(); idle();
        check("pre_rst_pulse", wp1, 1);
        #3 rst_n = 0;
        #1;
        check("async_rst_data", d1, 5);
        check("async_rst_pulse", wp1, 0);
        tick();
        check("rst_held_data", d1, 5);
        #3 rst_n = 1;
        tick();
        check("post_rst_hold", d1, 5);

        // Saturate with STEP=3, limit=10
        limit = 8'd10; sat_mode = 1;
        load(8'd0);
        inc = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat_up[%0d]", i), d3, exp_sat_up[i]);
            check($sformatf("sat_up_pulse[%0d]", i), wp3, 0);
        end
        idle(); dec = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat_dn[%0d]", i), d3, exp_sat_dn[i]);
            check($sformatf("sat_dn_pulse[%0d]", i), wp3, 0);
            check($sformatf("sat_dn_zero[%0d]", i), z3, (exp_sat_dn[i] == 0) ? 1 : 0);
        end
        idle();

        // Down wrap, STEP=1, limit=7
        limit = 8'd7; sat_mode = 0;
        load(8'd1);
        dec = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("dwrap[%0d]", i), d1, exp_dwrap[i]);
            check($sformatf("dwrap_pulse[%0d]", i), wp1, exp_dwrap_p[i]);
        end
        idle();

        // Priority
        limit = 8'd20;
        clr = 1; we = 1; inc = 1; data_in = 8'd12;
        tick();
        check("prio_clr", d1, 0);
        clr = 0;
        tick();
        check("prio_we", d1, 12);
        we = 0; dec = 1;
        tick();
        check("prio_incdec_hold", d1, 12);
        check("prio_incdec_pulse", wp1, 0);
        idle();

        // Limit changes affect flags immediately but never the count
        limit = 8'd5;
        tick();
        check("limit_drop_hold", d1, 12);
        limit = 8'd12;
        #1;
        check("at_limit_comb", al1, 1);

        // Out-of-range start value
        limit = 8'd200; sat_mode = 0;
        load(8'd250);
        inc = 1; tick(); idle();
        check("oor_wrap_data", d1, 0);
        check("oor_wrap_pulse", wp1, 1);
        sat_mode = 1;
        load(8'd250);
        inc = 1; tick(); idle();
        check("oor_sat_data", d1, 200);
        check("oor_sat_pulse", wp1, 0);

        // Overflow past 255 with STEP=10
        limit = 8'd255; sat_mode = 1;
        load(8'd250);
        inc = 1; tick(); idle();
        check("ovf_sat_data", d10, 255);
        check("ovf_sat_pulse", wp10, 0);
        sat_mode = 0;
        load(8'd250);
        inc = 1; tick(); idle();
        check("ovf_wrap_data", d10, 0);
        check("ovf_wrap_pulse", wp10, 1);

        // limit=0 in wrap mode pulses on every inc
        limit = 8'd0; sat_mode = 0;
        clr = 1; tick(); clr = 0;
        inc = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("lim0_data[%0d]", i), d1, 0);
            check($sformatf("lim0_pulse[%0d]", i), wp1, 1);
        end
        idle();
        tick();
        check("lim0_pulse_clear", wp1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_inc_wrap.md
# register_inc_wrap

Parametrised successor to the 8-bit incrementing register. It adds:
- configurable width and step;
- a programmable limit;
- up/down counting;
- wrap or saturate mode;
- terminal-count flags and a registered wrap pulse for chaining nested loop counters.

It sits in the matrix-multiply controller as the row/column/inner-product index counter feeding the address generators.

## Interface
- WIDTH, 8, width of data_in, data_out and limit
- STEP, 1, increment/decrement amount (1 ≤ STEP ≤ 2^WIDTH−1)
- RESET_VAL, 0, value loaded into data_out on reset

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear to 0
- we  in  1  synchronous load of data_in
- inc  in  1  count up by STEP
- dec  in  1  count down by STEP
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap
- limit  in  WIDTH  upper bound (inclusive) for counting
- data_in  in  WIDTH  load value
- data_out  out  WIDTH  registered count
- at_limit  out  1  combinational, data_out == limit
- zero  out  1  combinational, data_out == 0
- wrap_pulse  out  1  registered, one-cycle pulse after a wrap event

## Operation
- Priority per edge: clr > we > (inc xor dec) > hold.
- inc and dec both high: hold, no pulse.
- clr: data_out ← 0; wrap_pulse ← 0.
- we: data_out ← data_in, unclipped even if data_in > limit; wrap_pulse ← 0.
- Up count, with sum computed in WIDTH+1 bits:
  - If data_out + STEP ≤ limit: data_out ← data_out + STEP.
  - Otherwise, wrap mode: data_out ← 0 and wrap_pulse ← 1.
  - Otherwise, sat mode: data_out ← limit and no pulse.
- Down count:
  - If data_out ≥ STEP: data_out ← data_out − STEP.
  - Otherwise, wrap mode: data_out ← limit and wrap_pulse ← 1.
  - Otherwise, sat mode: data_out ← 0 and no pulse.
- Arithmetic never truncates silently: the WIDTH+1-bit sum detects overflow past 2^WIDTH−1, which is treated as exceeding limit.
- limit is sampled every cycle. Changing limit never modifies data_out directly; it only affects the next inc/dec decision.
- data_out > limit (after a load or a limit decrease), then inc:
  - wrap mode → 0 with pulse;
  - sat mode → limit, which pulls the value down to the bound.
- limit = 0, wrap mode, inc: data_out stays 0 and wrap_pulse fires on every inc cycle.
- wrap_pulse in all other cases (hold, non-wrapping count, saturation) is 0 on the next edge. It is never high for more than one cycle per wrap event.

## Timing
- Reset: rst_n low immediately forces data_out = RESET_VAL and wrap_pulse = 0, independent of clk. at_limit and zero follow combinationally.
- Release of rst_n is synchronous in effect: the first update occurs on the first rising edge with rst_n high.
- Latency:
  - Control inputs take effect on data_out at the next rising edge (1 cycle).
  - at_limit and zero respond in the same cycle as data_out changes.
  - wrap_pulse is high for exactly the cycle following the wrapping edge.
- Chaining: an outer counter's inc is tied to the inner counter's wrap_pulse. The outer counter advances one cycle after the inner counter wraps. Consumers needing zero-lag use at_limit & inc instead.
- Reset mid-count aborts immediately. There is no pending state; the next edge after release obeys normal priority.
- No handshake; every control is level-sampled each edge.

## Test plan
- Reset: WIDTH=8, RESET_VAL=5, assert rst_n=0 mid-cycle → data_out=5, wrap_pulse=0 before next edge; release, hold → stays 5.
- Wrap up: STEP=1, limit=3, sat_mode=0, clr then inc ×5 → data_out 1,2,3,0,1. wrap_pulse high only in the cycle after the 3→0 edge. at_limit high while data_out=3.
- Saturate/step: STEP=3, limit=10, sat_mode=1, load 0, inc ×5 → 3,6,9,10,10, no wrap_pulse. Then dec ×5 → 7,4,1,0,0, zero high at 0.
- Down wrap: STEP=1, limit=7, sat_mode=0, load 1, dec ×3 → 0,7,6, with wrap_pulse after the 0→7 edge.
- Priority: clr=we=inc=1, data_in=12 → 0. Then we=inc=1, data_in=12 → 12. Then inc=dec=1 → holds 12.
- Out-of-range/overflow: limit=200, load 250, inc (wrap) → 0 with pulse. WIDTH=8, STEP=10, limit=255, load 250, inc (sat) → 255 with no truncation to 4.
